// File: rtl/cla_pipe_adder.sv
// rtl/cla_pipe_adder.sv - two-stage pipelined carry-lookahead adder/subtractor with valid/ready handshakes
module cla_pipe_adder #(
    parameter int WIDTH = 32,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf
);
    localparam int NG = WIDTH / GROUP;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_p;
    logic [WIDTH-1:0] s1_g;
    logic [NG-1:0]    s1_gg;
    logic [NG-1:0]    s1_gp;
    logic             s1_cin;

    logic [WIDTH-1:0] bx;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic [NG-1:0]    gg;
    logic [NG-1:0]    gp;
    logic             cin;
    logic             gacc;

    logic [WIDTH-1:0] c;
    logic             carry;
    logic             cc;
    logic [WIDTH-1:0] nsum;
    logic             nco;
    logic             novf;

    logic adv2;
    logic accept;

    assign adv2     = s1_valid & (~out_valid | out_ready);
    assign in_ready = ~s1_valid | adv2;
    assign accept   = in_valid & in_ready;

    // Stage 1: operand conditioning and per-group generate/propagate
    always_comb begin
        bx   = sub ? ~b : b;
        cin  = sub ? 1'b1 : ci;
        p    = a ^ bx;
        g    = a & bx;
        gg   = '0;
        gp   = '0;
        gacc = 1'b0;
        for (int j = 0; j < NG; j++) begin
            gacc = 1'b0;
            for (int k = 0; k < GROUP; k++) begin
                gacc = g[j*GROUP+k] | (p[j*GROUP+k] & gacc);
            end
            gg[j] = gacc;
            gp[j] = &p[j*GROUP +: GROUP];
        end
    end

    // Stage 2: group carries via lookahead, ripple only inside each group
    always_comb begin
        c     = '0;
        carry = s1_cin;
        cc    = 1'b0;
        for (int j = 0; j < NG; j++) begin
            cc = carry;
            for (int k = 0; k < GROUP; k++) begin
                c[j*GROUP+k] = cc;
                cc = s1_g[j*GROUP+k] | (s1_p[j*GROUP+k] & cc);
            end
            carry = s1_gg[j] | (s1_gp[j] & carry);
        end
        nsum = s1_p ^ c;
        nco  = carry;
        novf = carry ^ c[WIDTH-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_p      <= '0;
            s1_g      <= '0;
            s1_gg     <= '0;
            s1_gp     <= '0;
            s1_cin    <= 1'b0;
            out_valid <= 1'b0;
            sum       <= '0;
            co        <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_p     <= p;
                s1_g     <= g;
                s1_gg    <= gg;
                s1_gp    <= gp;
                s1_cin   <= cin;
            end else if (adv2) begin
                s1_valid <= 1'b0;
            end

            if (adv2) begin
                out_valid <= 1'b1;
                sum       <= nsum;
                co        <= nco;
                ovf       <= novf;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb/tb_cla_pipe_adder.sv - scoreboard bench for cla_pipe_adder with randomized streaming
module tb_cla_pipe_adder;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         ci = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         co;
    logic         ovf;

    int vectors = 0;
    int miscompares = 0;
    int pops = 0;
    logic [W+1:0] exp_q[$];
    logic drv_done = 1'b0;

    cla_pipe_adder #(.WIDTH(W), .GROUP(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ci(ci), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .co(co), .ovf(ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // {co, ovf, sum} from plain unsigned/signed integer arithmetic
    function automatic logic [W+1:0] ref_model(input logic [W-1:0] x, input logic [W-1:0] y,
                                               input logic c_in, input logic s);
        longint ux, uy, ures, sres, lim;
        logic   c, o;
        ux  = longint'(x);
        uy  = longint'(y);
        lim = longint'(1) << (W - 1);
        if (s) begin
            ures = ux - uy;
            c    = (ux >= uy);
            sres = longint'($signed(x)) - longint'($signed(y));
        end else begin
            ures = ux + uy + longint'(c_in);
            c    = ures[W];
            sres = longint'($signed(x)) + longint'($signed(y)) + longint'(c_in);
        end
        o = (sres >= lim) || (sres < -lim);
        return {c, o, ures[W-1:0]};
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(W-1){1'b0}}};
            3:       return {1'b0, {(W-1){1'b1}}};
            default: return $urandom;
        endcase
    endfunction

    task automatic send(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xci,
                        input logic xs, input logic [W+1:0] e);
        bit done = 0;
        a = xa; b = xb; ci = xci; sub = xs; in_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(e);
                done = 1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout actual=not_accepted required=accepted");
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        chk("drain_left", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    // Monitor: pops the scoreboard on every consumed beat and checks stall stability
    logic         held = 1'b0;
    logic [W+1:0] hold_v = '0;
    logic [W+1:0] mon_e;
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                held = 1'b0;
            end else begin
                if (held)
                    chk("stall_hold", 64'({out_valid, co, ovf, sum}), 64'({1'b1, hold_v}));
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_result actual=%h required=none", {co, ovf, sum});
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("result", 64'({co, ovf, sum}), 64'(mon_e));
                        pops++;
                    end
                end
                held   = out_valid && !out_ready;
                hold_v = {co, ovf, sum};
            end
        end
    end

    logic [W-1:0] x1, y1, x2, y2, x3, y3, hold_sum;
    logic         s3, seen;
    int           base;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_co_ovf", 64'({co, ovf}), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;

        send(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, {1'b1, 1'b0, 32'h0000_0000});
        @(negedge clk);
        chk("latency_cycle1_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("latency_cycle2_out_valid", 64'(out_valid), 64'd1);
        @(posedge clk); #1;

        send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, {1'b0, 1'b1, 32'h8000_0000});
        send(32'h0000_000F, 32'h1, 1'b0, 1'b0, {1'b0, 1'b0, 32'h0000_0010});
        send(32'h5, 32'h7, 1'b1, 1'b1, {1'b0, 1'b0, 32'hFFFF_FFFE});
        send(32'h8000_0000, 32'h1, 1'b0, 1'b1, {1'b1, 1'b1, 32'h7FFF_FFFF});
        drain();

        // Backpressure: two beats fill the pipe, the third must wait
        out_ready = 1'b0;
        base = pops;
        x1 = $urandom; y1 = $urandom; x2 = $urandom; y2 = $urandom;
        x3 = $urandom; y3 = $urandom; s3 = 1'b1;
        send(x1, y1, 1'b0, 1'b0, ref_model(x1, y1, 1'b0, 1'b0));
        send(x2, y2, 1'b1, 1'b0, ref_model(x2, y2, 1'b1, 1'b0));
        a = x3; b = y3; ci = 1'b0; sub = s3; in_valid = 1'b1;
        @(negedge clk);
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        hold_sum = sum;
        repeat (4) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("bp_result1_held", 64'({out_valid, sum}), 64'({1'b1, hold_sum}));
            chk("bp_in_ready_stalled", 64'(in_ready), 64'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(x3, y3, 1'b0, s3, ref_model(x3, y3, 1'b0, s3));
        @(negedge clk);
        @(negedge clk); #1;
        chk("bp_results_drained", 64'(pops - base), 64'd3);
        @(posedge clk); #1;
        drain();

        // Reset between edges with two beats in flight
        out_ready = 1'b0;
        send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, ref_model(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0));
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, ref_model(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0));
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_sum", 64'(sum), 64'd0);
        chk("midrst_co_ovf", 64'({co, ovf}), 64'd0);
        exp_q.delete();
        @(negedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        chk("midrst_no_stale", 64'(seen), 64'd0);
        @(posedge clk); #1;

        // Randomized streaming with random gaps and random consumer stalls
        fork
            begin
                logic [W-1:0] ra, rb;
                logic         rc, rs;
                for (int n = 0; n < 1000; n++) begin
                    ra = pick(); rb = pick();
                    rc = 1'($urandom_range(0, 1));
                    rs = 1'($urandom_range(0, 1));
                    send(ra, rb, rc, rs, ref_model(ra, rb, rc, rs));
                    repeat ($urandom_range(0, 2) == 0 ? 1 : 0) begin
                        @(posedge clk); #1;
                    end
                end
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
